tt_io_buffer_bank: RTL and testbench

Parametrised bank of WIDTH digital pad buffers that replaces the single fixed-function pad buffer in the user tile. Each channel has a runtime-selectable mode: input, push-pull, open-drain, or disabled. Pad input is read back through a synchroniser and a debounce filter, and sticky rise/fall flags capture edges. The bank sits between the tile pins (ui_in/uo_out/uio_*) and core logic; one bank instance serves one pin group.

---
 rtl/tt_io_buffer_bank.sv | 149 ++++++++++++++
 tb/tb_tt_io_buffer_bank.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/tt_io_buffer_bank.sv
// Bank of WIDTH digital pad buffers: per-channel mode (input / push-pull /
// open-drain / disabled), synchronised + debounced readback, sticky edge flags.

module tt_io_buffer_ch #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       cfg_wr,
  input  logic [1:0] cfg_mode,
  input  logic       core_out,
  input  logic       flag_clr,
  input  logic       pad_in,
  output logic       pad_out,
  output logic       pad_oe,
  output logic       core_in,
  output logic       rise_flag,
  output logic       fall_flag
);
  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

  typedef enum logic [1:0] {M_IN = 2'b00, M_PP = 2'b01, M_OD = 2'b10, M_DIS = 2'b11} mode_e;

  mode_e                  mode_q, mode_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic pad_out_q, pad_out_d, pad_oe_q, pad_oe_d;
  logic core_in_q, core_in_d, rise_q, rise_d, fall_q, fall_d;
  logic sync_s;

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    mode_d    = mode_q;
    sync_d    = sync_q;
    cnt_d     = cnt_q;
    core_in_d = core_in_q;
    rise_d    = rise_q;
    fall_d    = fall_q;
    pad_out_d = 1'b0;
    pad_oe_d  = 1'b0;
    if (ena) begin
      if (cfg_wr) mode_d = mode_e'(cfg_mode);
      sync_d = {sync_q[SYNC_STAGES-2:0], pad_in};
      case (mode_q)
        M_PP:    begin pad_oe_d = 1'b1; pad_out_d = core_out; end
        M_OD:    pad_oe_d = ~core_out;
        default: ;
      endcase
      if (flag_clr) begin
        rise_d = 1'b0;
        fall_d = 1'b0;
      end
      // Forced drop in DISABLED is not a pad event, so no flag is raised.
      if (mode_q == M_DIS) begin
        cnt_d     = '0;
        core_in_d = 1'b0;
      end else if (sync_s == core_in_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        cnt_d     = '0;
        core_in_d = sync_s;
        if (sync_s) rise_d = 1'b1;
        else        fall_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= M_IN;
      sync_q    <= '0;
      cnt_q     <= '0;
      core_in_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      pad_out_q <= 1'b0;
      pad_oe_q  <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      core_in_q <= core_in_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      pad_out_q <= pad_out_d;
      pad_oe_q  <= pad_oe_d;
    end
  end

  assign pad_out   = pad_out_q;
  assign pad_oe    = pad_oe_q;
  assign core_in   = core_in_q;
  assign rise_flag = rise_q;
  assign fall_flag = fall_q;
endmodule

module tt_io_buffer_bank #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  localparam int SEL_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             cfg_we,
  input  logic [SEL_W-1:0] cfg_sel,
  input  logic [1:0]       cfg_mode,
  input  logic [WIDTH-1:0] core_out,
  input  logic [WIDTH-1:0] flag_clr,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] pad_out,
  output logic [WIDTH-1:0] pad_oe,
  output logic [WIDTH-1:0] core_in,
  output logic [WIDTH-1:0] rise_flag,
  output logic [WIDTH-1:0] fall_flag
);
  logic [WIDTH-1:0] cfg_hit;

  // Out-of-range selects match no lane, so they fall away naturally.
  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    assign cfg_hit[g] = cfg_we && (cfg_sel == SEL_W'(g));

    tt_io_buffer_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .cfg_wr    (cfg_hit[g]),
      .cfg_mode  (cfg_mode),
      .core_out  (core_out[g]),
      .flag_clr  (flag_clr[g]),
      .pad_in    (pad_in[g]),
      .pad_out   (pad_out[g]),
      .pad_oe    (pad_oe[g]),
      .core_in   (core_in[g]),
      .rise_flag (rise_flag[g]),
      .fall_flag (fall_flag[g])
    );
  end
endmodule

// File: tb/tb_tt_io_buffer_bank.sv
// Bench for tt_io_buffer_bank: edge-level behavioural model compared every
// cycle, plus directed literal checks; a 5-lane instance covers invalid selects.

module tb_tt_io_buffer_bank;
  localparam int W    = 8;
  localparam int SYNC = 2;
  localparam int FILT = 4;

  logic clk, rst_n, ena, cfg_we;
  logic [2:0] cfg_sel;
  logic [1:0] cfg_mode;
  logic [W-1:0] core_out, flag_clr, pad_in;
  logic [W-1:0] pad_out, pad_oe, core_in, rise_flag, fall_flag;

  logic b_cfg_we;
  logic [2:0] b_cfg_sel;
  logic [1:0] b_cfg_mode;
  logic [4:0] b_core_out, b_pad_out, b_pad_oe, b_core_in, b_rise, b_fall;

  int checks = 0;
  int errors = 0;

  tt_io_buffer_bank #(.WIDTH(W), .SYNC_STAGES(SYNC), .FILTER_LEN(FILT)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_mode(cfg_mode), .core_out(core_out), .flag_clr(flag_clr), .pad_in(pad_in),
    .pad_out(pad_out), .pad_oe(pad_oe), .core_in(core_in),
    .rise_flag(rise_flag), .fall_flag(fall_flag));

  tt_io_buffer_bank #(.WIDTH(5), .SYNC_STAGES(SYNC), .FILTER_LEN(FILT)) dut5 (
    .clk(clk), .rst_n(rst_n), .ena(1'b1), .cfg_we(b_cfg_we), .cfg_sel(b_cfg_sel),
    .cfg_mode(b_cfg_mode), .core_out(b_core_out), .flag_clr(5'd0), .pad_in(5'd0),
    .pad_out(b_pad_out), .pad_oe(b_pad_oe), .core_in(b_core_in),
    .rise_flag(b_rise), .fall_flag(b_fall));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: the pad value seen by the filter is the one sampled SYNC enabled
  // edges ago; a level is accepted after FILT consecutive disagreeing edges.
  int m_mode[W];
  int m_run[W];
  logic [W-1:0] m_core, m_rise, m_fall, m_oe, m_out, seen;
  logic [W-1:0] pad_log[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < W; c++) begin m_mode[c] = 0; m_run[c] = 0; end
      m_core = '0; m_rise = '0; m_fall = '0; m_oe = '0; m_out = '0;
      pad_log.delete();
    end else if (!ena) begin
      m_oe = '0; m_out = '0;
    end else begin
      seen = (pad_log.size() >= SYNC) ? pad_log[pad_log.size() - SYNC] : '0;
      pad_log.push_back(pad_in);
      for (int c = 0; c < W; c++) begin
        m_oe[c]  = (m_mode[c] == 1) ? 1'b1 : (m_mode[c] == 2) ? ~core_out[c] : 1'b0;
        m_out[c] = (m_mode[c] == 1) ? core_out[c] : 1'b0;
        if (flag_clr[c]) begin m_rise[c] = 1'b0; m_fall[c] = 1'b0; end
        if (m_mode[c] == 3) begin
          m_core[c] = 1'b0; m_run[c] = 0;
        end else if (seen[c] != m_core[c]) begin
          m_run[c]++;
          if (m_run[c] == FILT) begin
            m_core[c] = seen[c]; m_run[c] = 0;
            if (seen[c]) m_rise[c] = 1'b1; else m_fall[c] = 1'b1;
          end
        end else begin
          m_run[c] = 0;
        end
      end
      if (cfg_we && int'(cfg_sel) < W) m_mode[cfg_sel] = int'(cfg_mode);
    end
  end

  always @(posedge clk) begin
    #1;
    chk("cmp pad_out",   32'(pad_out),   32'(m_out));
    chk("cmp pad_oe",    32'(pad_oe),    32'(m_oe));
    chk("cmp core_in",   32'(core_in),   32'(m_core));
    chk("cmp rise_flag", 32'(rise_flag), 32'(m_rise));
    chk("cmp fall_flag", 32'(fall_flag), 32'(m_fall));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg(input int sel, input int mode);
    cfg_we = 1'b1; cfg_sel = 3'(sel); cfg_mode = 2'(mode);
    tick(1);
    cfg_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; cfg_we = 1'b0; cfg_sel = '0; cfg_mode = '0;
    core_out = 8'hFF; flag_clr = '0; pad_in = 8'hFF;
    b_cfg_we = 1'b0; b_cfg_sel = '0; b_cfg_mode = '0; b_core_out = 5'h1F;

    // Reset state with pads and core driven high
    tick(2);
    chk("reset pad_oe", 32'(pad_oe), 0);
    chk("reset pad_out", 32'(pad_out), 0);
    chk("reset core_in", 32'(core_in), 0);
    chk("reset flags", 32'({rise_flag, fall_flag}), 0);
    rst_n = 1'b1;
    tick(5);
    chk("latency core_in edge5", 32'(core_in), 0);
    tick(1);
    chk("latency core_in edge6", 32'(core_in), 32'hFF);
    chk("latency rise edge6", 32'(rise_flag), 32'hFF);

    // Return all lanes low and clear flags
    pad_in = 8'h00;
    tick(8);
    flag_clr = 8'hFF; tick(1); flag_clr = '0;
    chk("cleared flags", 32'({rise_flag, fall_flag}), 0);

    // Debounce: 3-cycle pulse rejected, held level accepted at edge 6
    pad_in[0] = 1'b1; tick(3); pad_in[0] = 1'b0;
    tick(10);
    chk("short pulse core_in0", 32'(core_in[0]), 0);
    chk("short pulse rise0", 32'(rise_flag[0]), 0);
    pad_in[0] = 1'b1;
    tick(5);
    chk("debounce edge5 core_in0", 32'(core_in[0]), 0);
    tick(1);
    chk("debounce edge6 core_in0", 32'(core_in[0]), 1);
    chk("debounce rise0", 32'(rise_flag[0]), 1);

    // Modes: ch3 push-pull, ch4 open-drain
    cfg(3, 1);
    cfg(4, 2);
    core_out = 8'h00; tick(1);
    chk("pp oe3 out3", 32'({pad_oe[3], pad_out[3]}), 32'b10);
    chk("od oe4 out4", 32'({pad_oe[4], pad_out[4]}), 32'b10);
    core_out = 8'hFF; tick(1);
    chk("pp out3 high", 32'(pad_out[3]), 1);
    chk("od oe4 released", 32'(pad_oe[4]), 0);
    chk("pad_oe vector", 32'(pad_oe), 32'h08);

    // Invalid select on the 5-lane bank is dropped, valid one lands
    b_cfg_we = 1'b1; b_cfg_mode = 2'd1; b_cfg_sel = 3'd5; tick(1);
    b_cfg_sel = 3'd7; tick(1);
    b_cfg_we = 1'b0; tick(2);
    chk("invalid sel oe", 32'(b_pad_oe), 0);
    b_cfg_we = 1'b1; b_cfg_sel = 3'd4; tick(1);
    b_cfg_we = 1'b0; tick(1);
    chk("valid sel oe", 32'(b_pad_oe), 32'h10);
    chk("valid sel out", 32'(b_pad_out), 32'h10);

    // Flags on ch5: clear collides with an accepted fall
    pad_in[5] = 1'b1; tick(6);
    chk("ch5 rise", 32'({core_in[5], rise_flag[5]}), 32'b11);
    pad_in[5] = 1'b0; tick(5);
    flag_clr[5] = 1'b1; tick(1); flag_clr[5] = 1'b0;
    chk("set beats clear rise5", 32'(rise_flag[5]), 0);
    chk("set beats clear fall5", 32'(fall_flag[5]), 1);
    flag_clr[5] = 1'b1; tick(1); flag_clr[5] = 1'b0;
    chk("clr ch5 flags", 32'({rise_flag[5], fall_flag[5]}), 0);

    // Disable ch2 while high: forced low without a fall flag
    pad_in[2] = 1'b1; tick(6);
    chk("ch2 high", 32'(core_in[2]), 1);
    flag_clr[2] = 1'b1; tick(1); flag_clr[2] = 1'b0;
    cfg(2, 3);
    chk("ch2 high on write edge", 32'(core_in[2]), 1);
    tick(1);
    chk("ch2 disabled core_in", 32'(core_in[2]), 0);
    chk("ch2 disabled fall", 32'(fall_flag[2]), 0);

    // ena low: pads released, state frozen, clear ignored
    ena = 1'b0; tick(1);
    chk("ena0 pad_oe", 32'(pad_oe), 0);
    chk("ena0 pad_out", 32'(pad_out), 0);
    pad_in = ~pad_in; flag_clr = 8'hFF;
    tick(8);
    chk("ena0 core_in held", 32'(core_in), 32'h01);
    chk("ena0 rise held", 32'(rise_flag), 32'h01);
    flag_clr = '0; ena = 1'b1;
    tick(3);
    chk("ena1 pad_oe", 32'(pad_oe), 32'h08);

    // Asynchronous reset mid-filter
    #2 rst_n = 1'b0;
    #1;
    chk("async rst pad_oe", 32'(pad_oe), 0);
    chk("async rst core_in", 32'(core_in), 0);
    chk("async rst flags", 32'({rise_flag, fall_flag}), 0);
    tick(1);
    rst_n = 1'b1;
    tick(4);
    chk("post rst core_in", 32'(core_in), 0);
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
